fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Sequences one FFT-energy color computation per new FFT frame and commits the resulting 84-bit palette to the VGA color path only at the start of vertical sync, so the display never shows a palette change mid-frame. It sits between the FFT core's frame-ready flag, the FFT energy/color engine (start/done handshake), and the color input of the VGA output stage. It also counts frames it had to drop and engine timeouts for the debug display.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2_000_000: clock cycles allowed in RUN before abandoning the computation.
- `DEFAULT_COLOR`, default 84'hFFF_FF0_F0F_00F_0F0_D08_0FF: palette driven on `color_out` from reset until the first commit.

Ports:
- `clock` in 1: 100 MHz system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `fft_ready` in 1: FFT frame-ready level from the FFT core; a rising edge marks a new frame in BRAM.
- `adjusting` in 1: offset adjustment in progress; blocks new starts.
- `energy_start` out 1: one-cycle start pulse to the energy engine.
- `energy_done` in 1: engine finished; `color_in` is valid in this cycle.
- `color_in` in 84: engine palette, seven 12-bit RGB entries.
- `vsync_async` in 1: active-low VGA vsync from the 25 MHz domain.
- `color_out` out 84: committed palette to the VGA output stage.
- `busy` out 1: high when the state is not IDLE.
- `drop_count` out 8: saturating count of ignored frame edges.
- `timeout_count` out 8: saturating count of engine timeouts.
- `commit_count` out 16: wrapping count of palette commits.

## Operation
- Vsync path:
  - Two-flop synchronizer (`vs1`, `vs2`), then `vs_prev <= vs2`.
  - `vblank = vs_prev & ~vs2`, i.e. the falling edge.
- Ready edge: `rdy_prev <= fft_ready`; `rdy_edge = fft_ready & ~rdy_prev`.
- States:
  - IDLE:
    - `rdy_edge & ~adjusting` → RUN, with `energy_start` = 1 for that transition only.
    - `rdy_edge & adjusting` → stay IDLE, `drop_count`++.
  - RUN:
    - `timer` is 0 on entry and increments each cycle.
    - `energy_done` → latch `color_in` into `shadow`, go to HOLD.
    - Else `timer == TIMEOUT_CYCLES-1` → `timeout_count`++, go to IDLE, nothing latched.
  - HOLD:
    - `vblank` → `color_out <= shadow`, `commit_count`++, go to IDLE.
- Any `rdy_edge` while in RUN or HOLD increments `drop_count`. The frame is not queued.
- `energy_done` outside RUN is ignored.
- `adjusting` affects only the IDLE start decision. An in-flight RUN/HOLD completes normally.
- Simultaneous events:
  - `energy_done` and timeout in the same cycle: done wins, no timeout counted.
  - HOLD with `vblank` and `rdy_edge` in the same cycle: commit, then IDLE; the edge counts as a drop.
- `drop_count` and `timeout_count` saturate at 255. `commit_count` wraps 65535 → 0.
- `shadow` is internal and is never visible on `color_out` except through a commit.

## Timing
- Reset values:
  - state IDLE, `energy_start` 0, `busy` 0.
  - `color_out` = `DEFAULT_COLOR`, `shadow` = `DEFAULT_COLOR`.
  - All counters 0, `timer` 0.
  - `vs1`, `vs2`, `vs_prev` = 1; `rdy_prev` = 1.
  - Because `rdy_prev` resets to 1, `fft_ready` held high through reset release does not start a frame.
- Reset asserted mid-operation: returns to the reset values on the next edge, abandons any RUN/HOLD, and leaves `color_out` at `DEFAULT_COLOR`.
- All outputs are registered.
- Start latency: with `fft_ready` low at edge N-1 and high at edge N, `energy_start` is high for the cycle after edge N+1, and `busy` is high from edge N+1.
- Done latency: with `energy_done` sampled high at edge M, the state is HOLD after edge M+1 (`shadow` loaded).
- Commit latency: with `vsync_async` first sampled low at edge K, `color_out` and `commit_count` update at edge K+2 and the state is IDLE after K+2. Requires HOLD at K+1.
- A vsync falling edge that arrives before HOLD is not remembered. The commit waits for the next vsync.
- Timeout: `timeout_count` increments exactly `TIMEOUT_CYCLES` cycles after entering RUN if no done arrives.
- Back-to-back frames: a new start is possible one cycle after leaving HOLD or RUN.

## Test plan
Bench uses `TIMEOUT_CYCLES` = 100.
- Reset, then hold `fft_ready` high → `energy_start` never pulses, `color_out` = `DEFAULT_COLOR`, all counts 0.
- `fft_ready` edge; `energy_done` 10 cycles after start with `color_in` = 84'h123_456_789_ABC_DEF_012_345; vsync falls 50 cycles later → `color_out` changes exactly at K+2 to that value, `commit_count` = 1, `busy` low.
- `fft_ready` edge, no `energy_done` → `timeout_count` = 1 after 100 RUN cycles, `busy` low, `color_out` unchanged, `energy_start` pulsed once.
- Three `fft_ready` edges during RUN/HOLD plus one edge with `adjusting` = 1 in IDLE → `drop_count` = 4, only one `energy_start`.
- `energy_done` on the same cycle as `timer` = 99 → HOLD entered, `timeout_count` = 0. Then `vblank` coincident with `rdy_edge` → commit, `drop_count` +1, no new start.
- `reset` pulsed while in HOLD with `shadow` = 84'hABC… → after reset `color_out` = `DEFAULT_COLOR`, state IDLE, and a later vsync commits nothing.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Runs one energy/color computation per new FFT frame and commits the resulting
// palette to the VGA color path only on the falling edge of vsync.
module fft_frame_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [83:0] DEFAULT_COLOR  = 84'hFFF_FF0_F0F_00F_0F0_D08_0FF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fft_ready,
    input  logic        adjusting,
    output logic        energy_start,
    input  logic        energy_done,
    input  logic [83:0] color_in,
    input  logic        vsync_async,
    output logic [83:0] color_out,
    output logic        busy,
    output logic [7:0]  drop_count,
    output logic [7:0]  timeout_count,
    output logic [15:0] commit_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               vs1_q, vs1_d;
    logic               vs2_q, vs2_d;
    logic               vs_prev_q, vs_prev_d;
    logic               rdy_in_q, rdy_in_d;
    logic               rdy_prev_q, rdy_prev_d;
    logic               done_in_q, done_in_d;
    logic [83:0]        color_smp_q, color_smp_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [83:0]        shadow_q, shadow_d;
    logic [83:0]        color_out_q, color_out_d;
    logic [7:0]         drop_q, drop_d;
    logic [7:0]         timeout_q, timeout_d;
    logic [15:0]        commit_q, commit_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    logic               vblank;
    logic               rdy_edge;

    // fft_ready and the engine result are sampled once before use, so every
    // decision is made from registered values.
    assign vblank   = vs_prev_q & ~vs2_q;
    assign rdy_edge = rdy_in_q & ~rdy_prev_q;

    always_comb begin
        state_d     = state_q;
        vs1_d       = vsync_async;
        vs2_d       = vs1_q;
        vs_prev_d   = vs2_q;
        rdy_in_d    = fft_ready;
        rdy_prev_d  = rdy_in_q;
        done_in_d   = energy_done;
        color_smp_d = color_in;
        timer_d     = '0;
        shadow_d    = shadow_q;
        color_out_d = color_out_q;
        drop_d      = drop_q;
        timeout_d   = timeout_q;
        commit_d    = commit_q;
        start_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rdy_edge && !adjusting) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + 1'b1;
                if (done_in_q) begin
                    shadow_d = color_smp_q;
                    state_d  = ST_HOLD;
                end else if (timer_q == TIMER_LAST) begin
                    if (timeout_q != 8'hFF) begin
                        timeout_d = timeout_q + 8'd1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (vblank) begin
                    color_out_d = shadow_q;
                    commit_d    = commit_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame edge that cannot start a computation is counted, never queued.
        if (rdy_edge && (state_q != ST_IDLE || adjusting) && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vs1_q       <= 1'b1;
            vs2_q       <= 1'b1;
            vs_prev_q   <= 1'b1;
            rdy_in_q    <= 1'b1;
            rdy_prev_q  <= 1'b1;
            done_in_q   <= 1'b0;
            color_smp_q <= DEFAULT_COLOR;
            timer_q     <= '0;
            shadow_q    <= DEFAULT_COLOR;
            color_out_q <= DEFAULT_COLOR;
            drop_q      <= 8'd0;
            timeout_q   <= 8'd0;
            commit_q    <= 16'd0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            vs_prev_q   <= vs_prev_d;
            rdy_in_q    <= rdy_in_d;
            rdy_prev_q  <= rdy_prev_d;
            done_in_q   <= done_in_d;
            color_smp_q <= color_smp_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            color_out_q <= color_out_d;
            drop_q      <= drop_d;
            timeout_q   <= timeout_d;
            commit_q    <= commit_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign energy_start  = start_q;
    assign busy          = busy_q;
    assign color_out     = color_out_q;
    assign drop_count    = drop_q;
    assign timeout_count = timeout_q;
    assign commit_count  = commit_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: start/done/commit latencies, timeout,
// drop counting, coincident events and reset while holding a palette.
module tb_fft_frame_sequencer;

    localparam logic [83:0] DEF_COLOR = 84'hFFF_FF0_F0F_00F_0F0_D08_0FF;
    localparam logic [83:0] COLOR_A   = 84'h123_456_789_ABC_DEF_012_345;
    localparam logic [83:0] COLOR_B   = 84'h0A0_0B0_0C0_0D0_0E0_0F0_010;
    localparam logic [83:0] COLOR_C   = 84'h321_654_987_CBA_FED_210_543;
    localparam logic [83:0] COLOR_D   = 84'hABC_ABC_ABC_ABC_ABC_ABC_ABC;
    localparam logic [1:0]  S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fft_ready = 1'b1;
    logic        adjusting = 1'b0;
    logic        energy_start;
    logic        energy_done = 1'b0;
    logic [83:0] color_in = '0;
    logic        vsync_async = 1'b1;
    logic [83:0] color_out;
    logic        busy;
    logic [7:0]  drop_count;
    logic [7:0]  timeout_count;
    logic [15:0] commit_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    fft_frame_sequencer #(
        .TIMEOUT_CYCLES(100),
        .DEFAULT_COLOR (DEF_COLOR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fft_ready    (fft_ready),
        .adjusting    (adjusting),
        .energy_start (energy_start),
        .energy_done  (energy_done),
        .color_in     (color_in),
        .vsync_async  (vsync_async),
        .color_out    (color_out),
        .busy         (busy),
        .drop_count   (drop_count),
        .timeout_count(timeout_count),
        .commit_count (commit_count),
        .dbg_state    (dbg_state)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (energy_start) start_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Low for two samples then high for two: the edge is consumed on return.
    task automatic ready_toggle();
        fft_ready = 1'b0;
        step(2);
        fft_ready = 1'b1;
        step(2);
    endtask

    task automatic pulse_done(input logic [83:0] c);
        energy_done = 1'b1;
        color_in    = c;
        step(1);
        energy_done = 1'b0;
        color_in    = '0;
    endtask

    initial begin
        // Reset with fft_ready held high throughout
        step(3);
        reset = 1'b0;
        step(6);
        check("rst_start_cnt", 84'(start_cnt), 84'd0);
        check("rst_color", color_out, DEF_COLOR);
        check("rst_busy", 84'(busy), 84'd0);
        check("rst_state", 84'(dbg_state), 84'(S_IDLE));
        check("rst_drop", 84'(drop_count), 84'd0);
        check("rst_timeout", 84'(timeout_count), 84'd0);
        check("rst_commit", 84'(commit_count), 84'd0);

        // Normal frame: start latency, done latency, commit at K+2
        fft_ready = 1'b0;
        step(2);
        fft_ready = 1'b1;
        step(1);
        check("start_early_busy", 84'(busy), 84'd0);
        check("start_early_pulse", 84'(energy_start), 84'd0);
        step(1);
        check("start_pulse", 84'(energy_start), 84'd1);
        check("start_busy", 84'(busy), 84'd1);
        check("start_state", 84'(dbg_state), 84'(S_RUN));
        step(9);
        pulse_done(COLOR_A);
        check("done_lat_run", 84'(dbg_state), 84'(S_RUN));
        step(1);
        check("done_hold", 84'(dbg_state), 84'(S_HOLD));
        check("hold_color_unchanged", color_out, DEF_COLOR);
        step(50);
        vsync_async = 1'b0;
        step(2);
        check("commit_k1_color", color_out, DEF_COLOR);
        check("commit_k1_count", 84'(commit_count), 84'd0);
        step(1);
        check("commit_color", color_out, COLOR_A);
        check("commit_count1", 84'(commit_count), 84'd1);
        check("commit_busy", 84'(busy), 84'd0);
        check("commit_state", 84'(dbg_state), 84'(S_IDLE));
        vsync_async = 1'b1;
        step(4);

        // Timeout after 100 RUN cycles without done
        ready_toggle();
        check("to_state_run", 84'(dbg_state), 84'(S_RUN));
        step(99);
        check("to_before", 84'(timeout_count), 84'd0);
        check("to_before_state", 84'(dbg_state), 84'(S_RUN));
        step(1);
        check("to_count", 84'(timeout_count), 84'd1);
        check("to_busy", 84'(busy), 84'd0);
        check("to_state", 84'(dbg_state), 84'(S_IDLE));
        check("to_color", color_out, COLOR_A);
        check("to_starts", 84'(start_cnt), 84'd2);
        step(3);

        // Drops: two edges in RUN, one in HOLD, one in IDLE while adjusting
        ready_toggle();
        ready_toggle();
        ready_toggle();
        pulse_done(COLOR_B);
        step(1);
        check("drop_hold", 84'(dbg_state), 84'(S_HOLD));
        ready_toggle();
        vsync_async = 1'b0;
        step(3);
        check("drop_commit", color_out, COLOR_B);
        vsync_async = 1'b1;
        step(4);
        adjusting = 1'b1;
        ready_toggle();
        adjusting = 1'b0;
        step(2);
        check("drop_count4", 84'(drop_count), 84'd4);
        check("drop_starts", 84'(start_cnt), 84'd3);
        check("drop_idle", 84'(dbg_state), 84'(S_IDLE));
        check("drop_commit_cnt", 84'(commit_count), 84'd2);

        // Done coincident with timer == 99, then vblank coincident with an edge
        ready_toggle();
        step(98);
        energy_done = 1'b1;
        color_in    = COLOR_C;
        step(1);
        energy_done = 1'b0;
        color_in    = '0;
        check("race_run", 84'(dbg_state), 84'(S_RUN));
        step(1);
        check("race_hold", 84'(dbg_state), 84'(S_HOLD));
        check("race_timeout", 84'(timeout_count), 84'd1);
        fft_ready = 1'b0;
        step(2);
        vsync_async = 1'b0;
        step(1);
        fft_ready = 1'b1;
        step(2);
        check("coinc_color", color_out, COLOR_C);
        check("coinc_commit", 84'(commit_count), 84'd3);
        check("coinc_drop", 84'(drop_count), 84'd5);
        check("coinc_state", 84'(dbg_state), 84'(S_IDLE));
        vsync_async = 1'b1;
        step(3);
        check("coinc_no_start", 84'(start_cnt), 84'd4);
        check("coinc_busy", 84'(busy), 84'd0);

        // Reset while holding a palette
        ready_toggle();
        step(3);
        pulse_done(COLOR_D);
        step(1);
        check("rh_hold", 84'(dbg_state), 84'(S_HOLD));
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        check("rh_color", color_out, DEF_COLOR);
        check("rh_state", 84'(dbg_state), 84'(S_IDLE));
        check("rh_busy", 84'(busy), 84'd0);
        check("rh_commit", 84'(commit_count), 84'd0);
        check("rh_drop", 84'(drop_count), 84'd0);
        check("rh_timeout", 84'(timeout_count), 84'd0);
        vsync_async = 1'b0;
        step(4);
        check("rh_vs_color", color_out, DEF_COLOR);
        check("rh_vs_commit", 84'(commit_count), 84'd0);
        check("rh_starts", 84'(start_cnt), 84'd5);
        vsync_async = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
